// File: rtl/regdst_pkg.sv
// regdst_pkg
//   Shared definitions for the write-register destination select and the
//   pending-destination queue: RegDst encodings, default SP/RA register
//   numbers, and the rt/rd field positions inside a MIPS-style instruction.
package regdst_pkg;

  typedef enum logic [1:0] {
    RD_RT = 2'b00,
    RD_SP = 2'b01,
    RD_RA = 2'b10,
    RD_RD = 2'b11
  } regdst_e;

  localparam int unsigned SP_REG_DEF = 29;
  localparam int unsigned RA_REG_DEF = 31;

  localparam int unsigned RT_MSB = 20;
  localparam int unsigned RT_LSB = 16;
  localparam int unsigned RD_MSB = 15;
  localparam int unsigned RD_LSB = 11;

endpackage

// File: rtl/regdst_decode.sv
// regdst_decode
//   Combinational write-register destination select (legacy RegDst mux).
//   Ports:
//     seletor  in  [1:0]        RegDst: 00 rt, 01 SP_REG, 10 RA_REG, 11 rd
//     instr    in  [31:0]       instruction word (rt=[20:16], rd=[15:11])
//     dest     out [ADDR_W-1:0] selected destination register
module regdst_decode
  import regdst_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned SP_REG = SP_REG_DEF,
  parameter int unsigned RA_REG = RA_REG_DEF
) (
  input  logic [1:0]        seletor,
  input  logic [31:0]       instr,
  output logic [ADDR_W-1:0] dest
);

  logic [ADDR_W-1:0] rt_a;
  logic [ADDR_W-1:0] rd_a;

  // Fields are resized to the register address width (low bits kept).
  assign rt_a = ADDR_W'(instr[RT_MSB:RT_LSB]);
  assign rd_a = ADDR_W'(instr[RD_MSB:RD_LSB]);

  // Opcode/rs/shamt/funct bits are not part of the destination select.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[31:RT_MSB+1], instr[RD_LSB-1:0]};

  always_comb begin
    dest = rt_a;
    case (regdst_e'(seletor))
      RD_RT:   dest = rt_a;
      RD_SP:   dest = ADDR_W'(SP_REG);
      RD_RA:   dest = ADDR_W'(RA_REG);
      RD_RD:   dest = rd_a;
      default: dest = rt_a;
    endcase
  end

endmodule

// File: rtl/regdst_pending_queue.sv
// regdst_pending_queue
//   Decodes the write destination from the instruction and holds it in a
//   small in-order FIFO until its write-back retires, exporting a pending
//   write scoreboard and a source-operand hazard flag.
//   Ports:
//     clk, reset        clock (rising edge), synchronous active-high reset
//     seletor, instr    RegDst select and instruction for the decode
//     push, pop, flush  enqueue decoded dest / retire head / squash all
//     rs_q, rt_q        source register queries for the hazard flag
//     dest_now          combinational decoded destination
//     wr_reg_out        registered queue head (0 when empty)
//     head_valid        queue non-empty (registered)
//     full, empty, count  occupancy status
//     busy_mask         bit i set if a valid entry targets register i (i>0)
//     hazard            busy_mask[rs_q] | busy_mask[rt_q]
//     err_ovf, err_udf  sticky overflow / underflow flags (reset-only clear)
module regdst_pending_queue
  import regdst_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned SP_REG = SP_REG_DEF,
  parameter int unsigned RA_REG = RA_REG_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                seletor,
  input  logic [31:0]               instr,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      flush,
  input  logic [ADDR_W-1:0]         rs_q,
  input  logic [ADDR_W-1:0]         rt_q,
  output logic [ADDR_W-1:0]         dest_now,
  output logic [ADDR_W-1:0]         wr_reg_out,
  output logic                      head_valid,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count,
  output logic [(2**ADDR_W)-1:0]    busy_mask,
  output logic                      hazard,
  output logic                      err_ovf,
  output logic                      err_udf
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  cnt;

  logic              is_full;
  logic              is_empty;
  logic              do_push;
  logic              do_pop;
  logic              ovf_evt;
  logic              udf_evt;
  logic [PTR_W-1:0]  nxt_rd;
  logic [CNT_W-1:0]  nxt_cnt;
  logic [ADDR_W-1:0] nxt_head;

  regdst_decode #(
    .ADDR_W (ADDR_W),
    .SP_REG (SP_REG),
    .RA_REG (RA_REG)
  ) u_decode (
    .seletor (seletor),
    .instr   (instr),
    .dest    (dest_now)
  );

  assign is_full  = (cnt == CNT_W'(DEPTH));
  assign is_empty = (cnt == '0);

  // Flush overrides both request lines; a pop on a full queue frees the slot
  // the concurrent push needs, so push is accepted when full only with pop.
  assign do_pop  = pop  && !is_empty && !flush;
  assign do_push = push && (!is_full || pop) && !flush;
  assign ovf_evt = push && is_full && !pop && !flush;
  assign udf_evt = pop  && is_empty && !flush;

  assign nxt_rd  = do_pop ? rd_ptr + PTR_W'(1) : rd_ptr;
  assign nxt_cnt = cnt + CNT_W'(do_push) - CNT_W'(do_pop);

  // Next head comes from the slot being written this cycle only when every
  // older entry is gone (push into empty, or push+pop with one entry left).
  assign nxt_head = (do_push && (nxt_rd == wr_ptr)) ? dest_now : mem[nxt_rd];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      cnt        <= '0;
      head_valid <= 1'b0;
      wr_reg_out <= '0;
      err_ovf    <= 1'b0;
      err_udf    <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      cnt        <= '0;
      head_valid <= 1'b0;
      wr_reg_out <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= dest_now;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      rd_ptr     <= nxt_rd;
      cnt        <= nxt_cnt;
      head_valid <= (nxt_cnt != '0);
      wr_reg_out <= (nxt_cnt != '0) ? nxt_head : '0;
      if (ovf_evt) err_ovf <= 1'b1;
      if (udf_evt) err_udf <= 1'b1;
    end
  end

  // Slot i is valid when its distance from the head is below the occupancy.
  logic [PTR_W-1:0] off;
  always_comb begin
    busy_mask = '0;
    off       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off = PTR_W'(i) - rd_ptr;
      if (CNT_W'(off) < cnt) busy_mask[mem[i]] = 1'b1;
    end
    busy_mask[0] = 1'b0;
  end

  assign hazard = busy_mask[rs_q] | busy_mask[rt_q];
  assign full   = is_full;
  assign empty  = is_empty;
  assign count  = cnt;

endmodule
